// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle between the key-expansion sequencer, its key/start
// source, the upstream round-constant block and the AddRoundKey stage.
// START/KEY_IN/RCON_IN flow into the sequencer; everything else flows out.
interface aes_key_expand_seq_if;
  logic         START;
  logic [127:0] KEY_IN;
  logic [31:0]  RCON_IN;
  logic         RCON_STEP;
  logic [127:0] ROUND_KEY;
  logic [3:0]   ROUND_IDX;
  logic         KEY_VALID;
  logic         BUSY;
  logic         DONE;
  logic         RCON_ERR;

  modport master (
    output START, KEY_IN, RCON_IN,
    input  RCON_STEP, ROUND_KEY, ROUND_IDX,
    input  KEY_VALID, BUSY, DONE, RCON_ERR
  );

  modport slave (
    input  START, KEY_IN, RCON_IN,
    output RCON_STEP, ROUND_KEY, ROUND_IDX,
    output KEY_VALID, BUSY, DONE, RCON_ERR
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion, one round key every two cycles.
// Ports: CLK, RST_N (sync, active-low), bus (slave side of the bundle).
module aes_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic CLK,
  input  logic RST_N,
  aes_key_expand_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, STEP, CALC, REWIND, FIN
  } state_t;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  state_t       state;
  logic [7:0]   exp_rc;
  logic         rcon_step;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;
  logic         rcon_err;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [3:0]   idx_nxt;
  logic [7:0]   exp_nxt;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ bus.RCON_IN;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign idx_nxt = round_idx + 4'd1;
  assign exp_nxt = {exp_rc[6:0], 1'b0}
                 ^ (exp_rc[7] ? 8'h1b : 8'h00);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      exp_rc    <= 8'h01;
      rcon_step <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rcon_err  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            round_key <= bus.KEY_IN;
            round_idx <= '0;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            rcon_err  <= 1'b0;
            exp_rc    <= 8'h01;
            rcon_step <= 1'b1;
            state     <= STEP;
          end
        end
        STEP: begin
          rcon_step <= 1'b0;
          state     <= CALC;
        end
        CALC: begin
          round_key <= {n0, n1, n2, n3};
          round_idx <= idx_nxt;
          key_valid <= 1'b1;
          exp_rc    <= exp_nxt;
          if (bus.RCON_IN != {exp_rc, 24'h0})
            rcon_err <= 1'b1;
          // Round 10 also steps, wrapping upstream S10 -> S0.
          rcon_step <= 1'b1;
          if (idx_nxt < 4'(NR))
            state <= STEP;
          else
            state <= REWIND;
        end
        REWIND: begin
          rcon_step <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RCON_STEP = rcon_step;
  assign bus.ROUND_KEY = round_key;
  assign bus.ROUND_IDX = round_idx;
  assign bus.KEY_VALID = key_valid;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.RCON_ERR  = rcon_err;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: known vectors, random keys vs a
// FIPS-style expansion model, and an upstream round-constant model.
module tb_aes_key_expand_seq;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  aes_key_expand_seq_if bus ();

  aes_key_expand_seq dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 0) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
         ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input int s);
    logic [7:0] r;
    if (s == 0) return 8'h00;
    r = 8'h01;
    for (int i = 1; i < s; i++) r = xt(r);
    return r;
  endfunction

  // Upstream round-constant block: S0..S10, no reset.
  int up_st = 0;
  bit up_ld = 0;
  int up_ld_val = 0;
  always @(posedge CLK) begin
    if (up_ld) up_st <= up_ld_val;
    else if (bus.RCON_STEP) up_st <= (up_st == 10) ? 0 : up_st + 1;
  end
  assign bus.RCON_IN = {rcon_of(up_st), 24'h0};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Word-wise key schedule; rcon for round r comes from upstream state
  // st0+r, and mis[r] marks rounds where that differs from the true Rcon.
  task automatic model(input logic [127:0] key, input int st0,
                       output logic [127:0] mk [11], output bit mis [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    mis[0] = 0;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        rc = rcon_of((st0 + i/4) % 11);
        mis[i/4] = (rc != rcon_of(i/4));
        t = t ^ {rc, 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run(input logic [127:0] key, input int st0,
                     input bit spam, output logic [127:0] got [11]);
    logic [127:0] mk [11];
    bit mis [11];
    int nstep, nkv, r;
    bit e_kv, e_busy, e_done, e_err;
    model(key, st0, mk, mis);
    for (int i = 0; i < 11; i++) got[i] = '0;
    @(negedge CLK);
    up_ld_val = st0;
    up_ld = 1;
    @(negedge CLK);
    up_ld = 0;
    bus.KEY_IN = key;
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.KEY_IN = {$urandom, $urandom, $urandom, $urandom};
    if (!spam) bus.START = 1'b0;
    nstep = 0;
    nkv = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      e_kv   = (c % 2 == 0) && (c <= 20);
      e_busy = (c <= 20);
      e_done = (c == 21);
      e_err  = 0;
      for (int k = 1; k <= 10; k++)
        if (k <= c/2 && mis[k]) e_err = 1;
      chk("key_valid", bus.KEY_VALID, e_kv);
      chk("rcon_step", bus.RCON_STEP, e_kv);
      chk("busy", bus.BUSY, e_busy);
      chk("done", bus.DONE, e_done);
      chk("rcon_err", bus.RCON_ERR, e_err);
      if (bus.RCON_STEP) nstep++;
      if (bus.KEY_VALID) nkv++;
      if (e_kv) begin
        r = c / 2;
        chk("round_idx", bus.ROUND_IDX, r);
        chk("round_key", bus.ROUND_KEY, mk[r]);
        got[r] = bus.ROUND_KEY;
      end
      if (c >= 21) chk("key_hold", bus.ROUND_KEY, mk[10]);
      if (c == 22) bus.START = 1'b0;
    end
    chk("step_count", nstep, 11);
    chk("valid_count", nkv, 11);
    chk("upstream_rcon", bus.RCON_IN, {rcon_of(st0), 24'h0});
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  vec_t tbl [2];
  logic [127:0] got [11];
  logic [127:0] fips;

  initial begin
    tbl[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               r1:  128'ha0fafe1788542cb123a339392a6c7605,
               r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{key: 128'h0,
               r1:  128'h62636363626363636263636362636363,
               r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    fips = tbl[0].key;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    bus.START = 1'b0;
    bus.KEY_IN = '0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_key_valid", bus.KEY_VALID, 0);
    chk("rst_rcon_step", bus.RCON_STEP, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_err", bus.RCON_ERR, 0);
    chk("rst_idx", bus.ROUND_IDX, 0);
    chk("rst_key", bus.ROUND_KEY, 0);
    RST_N = 1'b1;

    for (int v = 0; v < 2; v++) begin
      run(tbl[v].key, 0, 0, got);
      chk("vec_r0", got[0], tbl[v].key);
      chk("vec_r1", got[1], tbl[v].r1);
      chk("vec_r10", got[10], tbl[v].r10);
    end

    run(fips, 0, 1, got);
    chk("spam_r10", got[10], tbl[0].r10);
    run({$urandom, $urandom, $urandom, $urandom}, 0, 0, got);

    run(fips, 3, 0, got);
    run(fips, 0, 0, got);
    chk("resync_r10", got[10], tbl[0].r10);

    @(negedge CLK);
    up_ld_val = 0;
    up_ld = 1;
    @(negedge CLK);
    up_ld = 0;
    bus.KEY_IN = fips;
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (11) @(negedge CLK);
    chk("mid_valid", bus.KEY_VALID, 1);
    chk("mid_idx", bus.ROUND_IDX, 5);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid_rst_valid", bus.KEY_VALID, 0);
    chk("mid_rst_step", bus.RCON_STEP, 0);
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_done", bus.DONE, 0);
    chk("mid_rst_err", bus.RCON_ERR, 0);
    chk("mid_rst_idx", bus.ROUND_IDX, 0);
    chk("mid_rst_key", bus.ROUND_KEY, 0);
    RST_N = 1'b1;
    run(fips, 0, 0, got);
    chk("post_rst_r1", got[1], tbl[0].r1);
    chk("post_rst_r10", got[10], tbl[0].r10);

    for (int n = 0; n < 4; n++)
      run({$urandom, $urandom, $urandom, $urandom}, 0, 0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
